// File: rtl/sdp_y_alu_pkg.sv
// Shared constants for the SDP Y-core ALU input path.
// The core and the output stage both pick up these widths and default depths.
package sdp_y_alu_pkg;

    localparam int ALU_IN_DW = 128;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_SCW   = 16;

endpackage

// File: rtl/sdp_y_sat_cnt.sv
// Generic saturating up-counter with a synchronous clear.
// Clear takes priority over increment; the count holds at all-ones once it gets there.
module sdp_y_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sdp_y_alu_in_pipe_fifo.sv
// FWFT elastic buffer in front of the Y-core ALU input channel.
// The upstream ready comes straight from a flop, so a full FIFO cannot pass a word through in the same cycle.
module sdp_y_alu_in_pipe_fifo
    import sdp_y_alu_pkg::*;
#(
    parameter int DW    = ALU_IN_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SCW   = DEF_SCW
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    input  logic                       alu_in_pvld,
    output logic                       alu_in_prdy,
    input  logic [DW-1:0]              alu_in_pd,
    output logic                       chn_alu_in_rsc_vz,
    input  logic                       chn_alu_in_rsc_lz,
    output logic [DW-1:0]              chn_alu_in_rsc_z,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    input  logic                       stall_clr,
    output logic [SCW-1:0]             stall_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          prdy_q, prdy_d;
    logic          push, pop, vz;

    assign vz   = (cnt_q != '0);
    assign push = alu_in_pvld & prdy_q;
    assign pop  = vz & chn_alu_in_rsc_lz;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        // Ready looks ahead at next occupancy so upstream can fill every entry without a bubble.
        prdy_d   = (cnt_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            prdy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            prdy_q   <= prdy_d;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= alu_in_pd;
        end
    end

    sdp_y_sat_cnt #(
        .W (SCW)
    ) u_stall_cnt (
        .clk_i  (nvdla_core_clk),
        .rstn_i (nvdla_core_rstn),
        .clr_i  (stall_clr),
        .inc_i  (alu_in_pvld & ~prdy_q),
        .cnt_o  (stall_cnt)
    );

    assign alu_in_prdy       = prdy_q;
    assign chn_alu_in_rsc_vz = vz;
    assign chn_alu_in_rsc_z  = mem_q[rd_ptr_q];
    assign fifo_cnt          = cnt_q;

endmodule

// File: tb/tb_sdp_y_alu_in_pipe_fifo.sv
// Bench for the ALU input FIFO: directed vector table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_sdp_y_alu_in_pipe_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 4;
    localparam int SCW   = 16;
    localparam int SMAX  = 65535;

    logic            clk = 1'b0;
    logic            rstn;
    logic            pvld;
    logic            prdy;
    logic [DW-1:0]   pd;
    logic            vz;
    logic            lz;
    logic [DW-1:0]   z;
    logic [2:0]      cnt;
    logic            clr;
    logic [SCW-1:0]  stall;

    int nchecks = 0;
    int nerr    = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    bit            m_prdy = 1'b0;
    int            m_stall = 0;
    int            npush = 0;

    always #5 clk = ~clk;

    sdp_y_alu_in_pipe_fifo dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .alu_in_pvld       (pvld),
        .alu_in_prdy       (prdy),
        .alu_in_pd         (pd),
        .chn_alu_in_rsc_vz (vz),
        .chn_alu_in_rsc_lz (lz),
        .chn_alu_in_rsc_z  (z),
        .fifo_cnt          (cnt),
        .stall_clr         (clr),
        .stall_cnt         (stall)
    );

    typedef struct {
        bit            rstn;
        bit            pvld;
        bit            lz;
        bit            clr;
        logic [DW-1:0] pd;
        bit            e_prdy;
        bit            e_vz;
        int            e_cnt;
        int            e_stall;
        logic [DW-1:0] e_z;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r, bit v, bit l, bit c, logic [DW-1:0] d,
                                bit ep, bit ev, int ec, int es, logic [DW-1:0] ez);
        vec_t t;
        t.rstn = r; t.pvld = v; t.lz = l; t.clr = c; t.pd = d;
        t.e_prdy = ep; t.e_vz = ev; t.e_cnt = ec; t.e_stall = es; t.e_z = ez;
        return t;
    endfunction

    // Model: queue semantics straight from the handshake rules.
    task automatic model_edge();
        bit mpush, mpop;
        if (!rstn) begin
            mq.delete();
            m_prdy  = 1'b0;
            m_stall = 0;
        end else begin
            mpush = pvld && m_prdy;
            mpop  = (mq.size() != 0) && lz;
            if (clr) m_stall = 0;
            else if (pvld && !m_prdy && m_stall < SMAX) m_stall++;
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                mq.push_back(pd);
                npush++;
            end
            m_prdy = (mq.size() != DEPTH);
        end
    endtask

    task automatic model_check();
        chk("prdy", DW'(prdy), DW'(m_prdy));
        chk("vz", DW'(vz), DW'(mq.size() != 0));
        chk("fifo_cnt", DW'(cnt), DW'(mq.size()));
        chk("stall_cnt", DW'(stall), DW'(m_stall));
        if (mq.size() != 0) chk("head", z, mq[0]);
    endtask

    task automatic step(input bit r, input bit v, input bit l, input bit c, input logic [DW-1:0] d);
        @(negedge clk);
        rstn = r; pvld = v; lz = l; clr = c; pd = d;
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && mq.size() != 0; k++) step(1, 0, 1, 0, '0);
        chk("drain_done", DW'(mq.size()), DW'(0));
    endtask

    initial begin
        rstn = 1'b0; pvld = 1'b0; lz = 1'b0; clr = 1'b0; pd = '0;

        // reset, fill to full, pop through the full boundary, clear stall
        tbl[0]  = mk(0, 1, 0, 0, 'h0,  0, 0, 0, 0, 'h0);
        tbl[1]  = mk(0, 1, 0, 0, 'h0,  0, 0, 0, 0, 'h0);
        tbl[2]  = mk(0, 1, 0, 0, 'h0,  0, 0, 0, 0, 'h0);
        tbl[3]  = mk(1, 1, 0, 0, 'hAA, 1, 0, 0, 1, 'h0);
        tbl[4]  = mk(1, 1, 0, 0, 'h1,  1, 1, 1, 1, 'h1);
        tbl[5]  = mk(1, 1, 0, 0, 'h2,  1, 1, 2, 1, 'h1);
        tbl[6]  = mk(1, 1, 0, 0, 'h3,  1, 1, 3, 1, 'h1);
        tbl[7]  = mk(1, 1, 0, 0, 'h4,  0, 1, 4, 1, 'h1);
        tbl[8]  = mk(1, 1, 1, 0, 'h5,  1, 1, 3, 2, 'h2);
        tbl[9]  = mk(1, 0, 1, 0, 'h0,  1, 1, 2, 2, 'h3);
        tbl[10] = mk(1, 0, 1, 0, 'h0,  1, 1, 1, 2, 'h4);
        tbl[11] = mk(1, 0, 1, 0, 'h0,  1, 0, 0, 2, 'h0);
        tbl[12] = mk(1, 0, 0, 1, 'h0,  1, 0, 0, 0, 'h0);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rstn, tbl[i].pvld, tbl[i].lz, tbl[i].clr, tbl[i].pd);
            chk($sformatf("vec%0d_prdy", i), DW'(prdy), DW'(tbl[i].e_prdy));
            chk($sformatf("vec%0d_vz", i), DW'(vz), DW'(tbl[i].e_vz));
            chk($sformatf("vec%0d_cnt", i), DW'(cnt), DW'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_stall", i), DW'(stall), DW'(tbl[i].e_stall));
            if (tbl[i].e_vz) chk($sformatf("vec%0d_z", i), z, tbl[i].e_z);
        end

        // streaming: one word per cycle, occupancy pinned at 1
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 1, 0, DW'(i));
            chk("stream_cnt", DW'(cnt), DW'(1));
            chk("stream_z", z, DW'(i));
        end
        drain();

        // wrap-around with lz alternating
        for (int i = 0; i < 10; i++) step(1, 1, i[0], 0, DW'(200 + i));
        drain();

        // random traffic
        npush = 0;
        for (int k = 0; k < 20000 && npush < 1000; k++)
            step(1, 1'($urandom), 1'($urandom), 0,
                 {$urandom, $urandom, $urandom, $urandom});
        chk("rand_pushes", DW'(npush), DW'(1000));
        drain();

        // stall counter
        for (int k = 0; k < 10 && m_prdy; k++) step(1, 1, 0, 0, DW'(300 + k));
        chk("filled", DW'(cnt), DW'(DEPTH));
        step(1, 0, 0, 1, '0);
        for (int k = 0; k < 20; k++) step(1, 1, 0, 0, '0);
        chk("stall_20", DW'(stall), DW'(20));
        step(1, 1, 0, 1, '0);
        chk("stall_clr", DW'(stall), DW'(0));
        for (int k = 0; k < 70000; k++) step(1, 1, 0, 0, '0);
        chk("stall_sat", DW'(stall), DW'(16'hFFFF));
        drain();

        // mid-operation reset
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, DW'(400 + k));
        chk("pre_rst_cnt", DW'(cnt), DW'(3));
        step(0, 0, 0, 0, '0);
        chk("midrst_cnt", DW'(cnt), DW'(0));
        chk("midrst_vz", DW'(vz), DW'(0));
        step(1, 0, 0, 0, '0);
        step(1, 1, 0, 0, DW'(128'hBEEF));
        chk("post_rst_head", z, DW'(128'hBEEF));
        chk("post_rst_vz", DW'(vz), DW'(1));
        step(1, 0, 1, 0, '0);
        chk("post_rst_empty", DW'(vz), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/sdp_y_alu_in_pipe_fifo.md
Name: sdp_y_alu_in_pipe_fifo

Overview:
- Elastic input buffer that feeds the SDP Y-core ALU input channel (chn_alu_in).
- Accepts 128-bit ALU operand words from the upstream SDP datapath on a valid/ready handshake and presents them to the core's input-channel wait logic as a first-word-fall-through (FWFT) queue.
- Decouples upstream timing from core stalls, registers the upstream ready, and exposes occupancy plus a stall-cycle counter for performance debug.

Parameters:
- DW, 128, data width of one ALU input word.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, log2(DEPTH), pointer width; derived, not overridable.
- SCW, 16, stall counter width.

Ports:
- nvdla_core_clk  in  1  core clock; all state updates on rising edge.
- nvdla_core_rstn  in  1  synchronous active-low reset.
- alu_in_pvld  in  1  upstream word valid.
- alu_in_prdy  out  1  upstream ready; driven directly from a flop.
- alu_in_pd  in  DW  upstream word.
- chn_alu_in_rsc_vz  out  1  valid to the core input channel; equals "not empty".
- chn_alu_in_rsc_lz  in  1  core ready; word consumed when vz and lz are both high.
- chn_alu_in_rsc_z  out  DW  head-of-queue word.
- fifo_cnt  out  AW+1  current occupancy, 0..DEPTH.
- stall_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  SCW  saturating count of upstream-blocked cycles.

Behaviour:
- **Reset.** Sampled on the clock edge while nvdla_core_rstn=0. All of the following then hold:
  - wr_ptr=0, rd_ptr=0, fifo_cnt=0, stall_cnt=0.
  - alu_in_prdy=0, chn_alu_in_rsc_vz=0.
  - Storage contents are not reset; chn_alu_in_rsc_z is don't-care while vz=0.
  - Reset asserted mid-operation discards all queued words at that edge.
- **First cycle after reset release.** alu_in_prdy rises to 1 at the first edge with rstn=1.
- **Push.** push = alu_in_pvld & alu_in_prdy. The word is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH (natural wrap).
- **Pop.** pop = chn_alu_in_rsc_vz & chn_alu_in_rsc_lz. rd_ptr increments modulo DEPTH.
- **Occupancy.** fifo_cnt_next = fifo_cnt + push - pop.
- **Simultaneous push and pop.** Count is unchanged and both pointers advance. This applies at any occupancy below DEPTH.
- **Ready flop.** alu_in_prdy_next = (fifo_cnt_next != DEPTH).
  - Upstream may therefore fill all DEPTH entries with no bubble.
  - When full and the core pops, prdy returns the following cycle. There is no same-cycle full pass-through.
- **Head word.** chn_alu_in_rsc_z = mem[rd_ptr] (FWFT). vz = (fifo_cnt != 0).
- **Latency.** There is no empty bypass. A word pushed at edge N is visible with vz=1 in the cycle after edge N. Minimum latency is 1 cycle.
- **Output stability.** While vz=1 and lz=0, chn_alu_in_rsc_z and vz stay stable.
- **Upstream side.** alu_in_pvld may drop without a transfer; the block tolerates this.
- **Underflow/overflow.** Both are impossible by construction, because push is gated by prdy and pop by vz.
- **Stall counter.**
  - Increments when alu_in_pvld=1 and alu_in_prdy=0.
  - Saturates at all-ones.
  - stall_clr has priority over increment: stall_cnt becomes 0 at that edge.
  - Reset also clears it.

Decomposition:
- **Shared package sdp_y_alu_pkg:** holds the ALU input width constant (128) and the default DEPTH/SCW constants, reused by the core and the output stage.
- **One sub-module, sdp_y_sat_cnt:** a generic saturating counter with clear and increment.
- **Remaining logic stays flat:** storage array, pointers and ready flop.

Test Plan:
- **Reset.** Hold rstn=0 for 3 cycles with pvld=1 -> prdy=0, vz=0, fifo_cnt=0, stall_cnt=0. Release -> prdy=1 on the next cycle.
- **Fill/drain.** With lz=0, push 0x1, 0x2, 0x3, 0x4 back-to-back -> fifo_cnt=4, prdy=0 the cycle after the 4th push. Raise lz -> core sees 0x1..0x4 in order, vz falls after the 4th pop, prdy=1 one cycle after the first pop.
- **Streaming.** pvld=1 and lz=1 continuously for 100 words (value = index) -> one word per cycle after a 1-cycle initial latency, order preserved, fifo_cnt stays at 1.
- **Wrap-around.** Perform 10 pushes/pops, interleaving lz off/on, so pointers wrap twice -> no loss or duplication. Random lz for 1000 words is checked against a scoreboard.
- **Stall counter.** Fill the FIFO, keep pvld=1 and lz=0 for 20 cycles -> stall_cnt=20. Assert stall_clr together with a stall cycle -> stall_cnt=0. Force 70000 stall cycles -> stall_cnt saturates at 0xFFFF.
- **Mid-operation reset.** With 3 words queued and lz=0, pulse rstn=0 for one cycle -> fifo_cnt=0 and vz=0 at the next cycle. A new word pushed afterwards is the first one delivered.
